// File: rtl/conv_inst_sched.sv
// Convolution instruction scheduler: turns one layer command into a sequence of
// 4-channel group instructions, handshaking each one with the conv pipeline.
module conv_inst_sched #(
  parameter int MaxAddrWidth  = 32,
  parameter int MaxPictWidth  = 9,
  parameter int MaxPixelNum   = 18,
  parameter int MaxGroupWidth = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic [MaxAddrWidth-1:0]  cmd_weight_base_in,
  input  logic [MaxAddrWidth-1:0]  cmd_data_base_in,
  input  logic [MaxPictWidth-1:0]  cmd_pict_size_in,
  input  logic [MaxGroupWidth-1:0] cmd_group_num_in,
  input  logic                     conv_done_in,
  output logic [MaxAddrWidth-1:0]  weight_addr0_out,
  output logic [MaxAddrWidth-1:0]  weight_addr1_out,
  output logic [MaxAddrWidth-1:0]  weight_addr2_out,
  output logic [MaxAddrWidth-1:0]  weight_addr3_out,
  output logic [MaxAddrWidth-1:0]  data_addr0_out,
  output logic [MaxAddrWidth-1:0]  data_addr1_out,
  output logic [MaxAddrWidth-1:0]  data_addr2_out,
  output logic [MaxAddrWidth-1:0]  data_addr3_out,
  output logic [MaxPictWidth-1:0]  pict_size_out,
  output logic                     conv_first_out,
  output logic                     conv_last_out,
  output logic                     inst_tag_out,
  output logic                     busy_out,
  output logic                     layer_done_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic [MaxAddrWidth-1:0] KERN_STEP  = MaxAddrWidth'(9);
  localparam logic [MaxAddrWidth-1:0] GROUP_STEP = MaxAddrWidth'(36);

  logic [1:0]               state_r;
  logic [MaxAddrWidth-1:0]  wbase_r;
  logic [MaxAddrWidth-1:0]  dbase_r;
  logic [MaxPictWidth-1:0]  pict_r;
  logic [MaxPixelNum-1:0]   plane_r;
  logic [MaxGroupWidth-1:0] gcnt_r;
  logic [MaxGroupWidth-1:0] gidx_r;
  logic                     fin_r;
  logic [MaxAddrWidth-1:0]  waddr_r [4];
  logic [MaxAddrWidth-1:0]  daddr_r [4];
  logic [MaxPictWidth-1:0]  pict_out_r;
  logic                     first_r;
  logic                     last_r;
  logic                     tag_r;
  logic                     busy_r;
  logic                     ready_r;
  logic                     layer_done_r;

  logic [2*MaxPictWidth-1:0] pict_ext_s;
  logic [2*MaxPictWidth-1:0] sq_s;
  logic [MaxAddrWidth-1:0]   plane_ext_s;
  logic [MaxGroupWidth-1:0]  gcnt_in_s;
  logic                      last_grp_s;

  assign pict_ext_s  = {{MaxPictWidth{1'b0}}, cmd_pict_size_in};
  assign sq_s        = pict_ext_s * pict_ext_s;
  assign plane_ext_s = MaxAddrWidth'(plane_r);
  assign last_grp_s  = (gidx_r == (gcnt_r - MaxGroupWidth'(1)));

  // A zero group count is treated as a single group.
  always_comb begin
    gcnt_in_s = cmd_group_num_in;
    if (cmd_group_num_in == {MaxGroupWidth{1'b0}}) begin
      gcnt_in_s = MaxGroupWidth'(1);
    end else begin
      gcnt_in_s = cmd_group_num_in;
    end
  end

  // Layer sequencing FSM with registered instruction outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r      <= ST_IDLE;
      wbase_r      <= {MaxAddrWidth{1'b0}};
      dbase_r      <= {MaxAddrWidth{1'b0}};
      pict_r       <= {MaxPictWidth{1'b0}};
      plane_r      <= {MaxPixelNum{1'b0}};
      gcnt_r       <= {MaxGroupWidth{1'b0}};
      gidx_r       <= {MaxGroupWidth{1'b0}};
      fin_r        <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        waddr_r[n] <= {MaxAddrWidth{1'b0}};
        daddr_r[n] <= {MaxAddrWidth{1'b0}};
      end
      pict_out_r   <= {MaxPictWidth{1'b0}};
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      tag_r        <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
      layer_done_r <= 1'b0;
    end else begin
      layer_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_in && ready_r) begin
            wbase_r <= cmd_weight_base_in;
            dbase_r <= cmd_data_base_in;
            pict_r  <= cmd_pict_size_in;
            plane_r <= MaxPixelNum'(sq_s);
            gcnt_r  <= gcnt_in_s;
            gidx_r  <= {MaxGroupWidth{1'b0}};
            fin_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_CALC: begin
          for (int n = 0; n < 4; n++) begin
            waddr_r[n] <= wbase_r + MaxAddrWidth'(n) * KERN_STEP;
            daddr_r[n] <= dbase_r + MaxAddrWidth'(n) * plane_ext_s;
          end
          first_r    <= (gidx_r == {MaxGroupWidth{1'b0}});
          last_r     <= last_grp_s;
          pict_out_r <= pict_r;
          state_r    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          tag_r   <= ~tag_r;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Last group finishes over two cycles so the done pulse never overlaps IDLE.
          if (layer_done_r) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end else if (fin_r) begin
            fin_r        <= 1'b0;
            layer_done_r <= 1'b1;
          end else if (conv_done_in) begin
            if (last_grp_s) begin
              fin_r <= 1'b1;
            end else begin
              wbase_r <= wbase_r + GROUP_STEP;
              dbase_r <= dbase_r + (plane_ext_s << 2);
              gidx_r  <= gidx_r + MaxGroupWidth'(1);
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign weight_addr0_out = waddr_r[0];
  assign weight_addr1_out = waddr_r[1];
  assign weight_addr2_out = waddr_r[2];
  assign weight_addr3_out = waddr_r[3];
  assign data_addr0_out   = daddr_r[0];
  assign data_addr1_out   = daddr_r[1];
  assign data_addr2_out   = daddr_r[2];
  assign data_addr3_out   = daddr_r[3];
  assign pict_size_out    = pict_out_r;
  assign conv_first_out   = first_r;
  assign conv_last_out    = last_r;
  assign inst_tag_out     = tag_r;
  assign busy_out         = busy_r;
  assign cmd_ready_out    = ready_r;
  assign layer_done_out   = layer_done_r;

endmodule

// File: tb/tb_conv_inst_sched.sv
// Self-checking bench for conv_inst_sched: directed scenarios plus randomized
// layers checked against an arithmetic address model.
module tb_conv_inst_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [31:0] cmd_weight_base_in;
  logic [31:0] cmd_data_base_in;
  logic [8:0]  cmd_pict_size_in;
  logic [7:0]  cmd_group_num_in;
  logic        conv_done_in;
  logic [31:0] weight_addr0_out, weight_addr1_out, weight_addr2_out, weight_addr3_out;
  logic [31:0] data_addr0_out, data_addr1_out, data_addr2_out, data_addr3_out;
  logic [8:0]  pict_size_out;
  logic        conv_first_out, conv_last_out, inst_tag_out, busy_out, layer_done_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] w_obs [4];
  logic [31:0] d_obs [4];

  conv_inst_sched dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_weight_base_in(cmd_weight_base_in), .cmd_data_base_in(cmd_data_base_in),
    .cmd_pict_size_in(cmd_pict_size_in), .cmd_group_num_in(cmd_group_num_in),
    .conv_done_in(conv_done_in),
    .weight_addr0_out(weight_addr0_out), .weight_addr1_out(weight_addr1_out),
    .weight_addr2_out(weight_addr2_out), .weight_addr3_out(weight_addr3_out),
    .data_addr0_out(data_addr0_out), .data_addr1_out(data_addr1_out),
    .data_addr2_out(data_addr2_out), .data_addr3_out(data_addr3_out),
    .pict_size_out(pict_size_out), .conv_first_out(conv_first_out),
    .conv_last_out(conv_last_out), .inst_tag_out(inst_tag_out),
    .busy_out(busy_out), .layer_done_out(layer_done_out)
  );

  always #5 Clk = ~Clk;

  // Collect per-channel outputs into arrays for loop-based comparison.
  always_comb begin
    w_obs[0] = weight_addr0_out; w_obs[1] = weight_addr1_out;
    w_obs[2] = weight_addr2_out; w_obs[3] = weight_addr3_out;
    d_obs[0] = data_addr0_out;   d_obs[1] = data_addr1_out;
    d_obs[2] = data_addr2_out;   d_obs[3] = data_addr3_out;
  end

  // Reference model: channel n of group g of a layer, modulo 2^32.
  function automatic logic [31:0] exp_w(input logic [31:0] wb, input int g, input int n);
    longint t;
    t = longint'(wb) + 64'd36 * longint'(g) + 64'd9 * longint'(n);
    return t[31:0];
  endfunction

  function automatic logic [31:0] exp_d(input logic [31:0] db, input int pict, input int g, input int n);
    longint t;
    t = longint'(db) + longint'(pict) * longint'(pict) * longint'(4 * g + n);
    return t[31:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] wb, input logic [31:0] db, input int ps, input int gn);
    cmd_weight_base_in = wb;
    cmd_data_base_in   = db;
    cmd_pict_size_in   = 9'(ps);
    cmd_group_num_in   = 8'(gn);
    cmd_valid_in       = 1'b1;
    tick();
    cmd_valid_in       = 1'b0;
  endtask

  task automatic pulse_done();
    conv_done_in = 1'b1;
    tick();
    conv_done_in = 1'b0;
  endtask

  task automatic wait_toggle(output int cyc);
    logic t0;
    t0  = inst_tag_out;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (inst_tag_out !== t0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_ldone(output int cyc, output int width);
    cyc   = -1;
    width = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (layer_done_out === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc > 0) begin
      width = 1;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (layer_done_out === 1'b1) width++;
        else break;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; cmd_valid_in = 1'b1; conv_done_in = 1'b1;
    cmd_weight_base_in = $urandom; cmd_data_base_in = $urandom;
    cmd_pict_size_in = 9'd7; cmd_group_num_in = 8'd3;
    tick();
    n_checks++;
    if ({w_obs[0], w_obs[1], w_obs[2], w_obs[3], d_obs[0], d_obs[1], d_obs[2], d_obs[3],
         pict_size_out, conv_first_out, conv_last_out, inst_tag_out, busy_out, layer_done_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero w0=%h d0=%h tag=%b busy=%b, want all 0",
                         w_obs[0], d_obs[0], inst_tag_out, busy_out);
    end
    n_checks++;
    if (cmd_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready_out); end
    tick();
    Rst = 1'b0; cmd_valid_in = 1'b0; conv_done_in = 1'b0;
    tick();
    n_checks++;
    if (busy_out !== 1'b0 || cmd_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: busy=%b ready=%b want 0/1", busy_out, cmd_ready_out);
    end
  endtask

  task automatic test_two_group();
    logic [31:0] ew0 [4] = '{32'h100, 32'h109, 32'h112, 32'h11B};
    logic [31:0] ed0 [4] = '{32'h1000, 32'h1019, 32'h1032, 32'h104B};
    logic [31:0] ew1 [4] = '{32'h124, 32'h12D, 32'h136, 32'h13F};
    logic [31:0] ed1 [4] = '{32'h1064, 32'h107D, 32'h1096, 32'h10AF};
    int c, w;
    logic t0;
    send_cmd(32'h100, 32'h1000, 5, 2);
    n_checks++;
    if (busy_out !== 1'b1 || cmd_ready_out !== 1'b0) begin
      n_fail++; $display("FAIL two_grp_accept: busy=%b ready=%b want 1/0", busy_out, cmd_ready_out);
    end
    wait_toggle(c);
    n_checks++;
    if (c !== 2) begin n_fail++; $display("FAIL two_grp_lat0: got %0d want 2", c); end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (w_obs[n] !== ew0[n] || d_obs[n] !== ed0[n]) begin
        n_fail++; $display("FAIL two_grp_g0_ch%0d: w=%h d=%h want %h %h", n, w_obs[n], d_obs[n], ew0[n], ed0[n]);
      end
    end
    n_checks++;
    if (conv_first_out !== 1'b1 || conv_last_out !== 1'b0 || pict_size_out !== 9'd5) begin
      n_fail++; $display("FAIL two_grp_g0_flags: first=%b last=%b pict=%0d want 1 0 5",
                         conv_first_out, conv_last_out, pict_size_out);
    end
    t0 = inst_tag_out;
    repeat (3) tick();
    n_checks++;
    if (inst_tag_out !== t0) begin n_fail++; $display("FAIL two_grp_single_toggle: tag=%b want %b", inst_tag_out, t0); end
    pulse_done();
    wait_toggle(c);
    n_checks++;
    if (c !== 2) begin n_fail++; $display("FAIL two_grp_lat1: got %0d want 2", c); end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (w_obs[n] !== ew1[n] || d_obs[n] !== ed1[n]) begin
        n_fail++; $display("FAIL two_grp_g1_ch%0d: w=%h d=%h want %h %h", n, w_obs[n], d_obs[n], ew1[n], ed1[n]);
      end
    end
    n_checks++;
    if (conv_first_out !== 1'b0 || conv_last_out !== 1'b1) begin
      n_fail++; $display("FAIL two_grp_g1_flags: first=%b last=%b want 0 1", conv_first_out, conv_last_out);
    end
    pulse_done();
    wait_ldone(c, w);
    n_checks++;
    if (c !== 1 || w !== 1) begin n_fail++; $display("FAIL two_grp_ldone: lat=%0d width=%0d want 1 1", c, w); end
    n_checks++;
    if (cmd_ready_out !== 1'b1 || busy_out !== 1'b0 || weight_addr3_out !== 32'h13F || conv_last_out !== 1'b1) begin
      n_fail++; $display("FAIL two_grp_after: ready=%b busy=%b w3=%h last=%b want 1 0 13f 1",
                         cmd_ready_out, busy_out, weight_addr3_out, conv_last_out);
    end
  endtask

  task automatic test_zero_groups();
    logic [31:0] wb, db;
    int ps, c, w;
    logic t0;
    wb = $urandom; db = $urandom; ps = $urandom_range(1, 511);
    t0 = inst_tag_out;
    send_cmd(wb, db, ps, 0);
    wait_toggle(c);
    n_checks++;
    if (c !== 2 || conv_first_out !== 1'b1 || conv_last_out !== 1'b1) begin
      n_fail++; $display("FAIL zero_grp_issue: lat=%0d first=%b last=%b want 2 1 1", c, conv_first_out, conv_last_out);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (w_obs[n] !== exp_w(wb, 0, n) || d_obs[n] !== exp_d(db, ps, 0, n)) begin
        n_fail++; $display("FAIL zero_grp_ch%0d: w=%h d=%h want %h %h", n, w_obs[n], d_obs[n],
                           exp_w(wb, 0, n), exp_d(db, ps, 0, n));
      end
    end
    pulse_done();
    wait_ldone(c, w);
    n_checks++;
    if (c !== 1 || w !== 1 || inst_tag_out !== ~t0) begin
      n_fail++; $display("FAIL zero_grp_end: lat=%0d width=%0d tag=%b want 1 1 %b", c, w, inst_tag_out, ~t0);
    end
  endtask

  task automatic test_valid_held();
    logic [31:0] wa, da, wb, db;
    int pa, pb, c, w;
    Rst = 1'b1; tick(); Rst = 1'b0;
    wa = $urandom; da = $urandom; pa = $urandom_range(1, 511);
    wb = $urandom; db = $urandom; pb = $urandom_range(1, 511);
    cmd_weight_base_in = wa; cmd_data_base_in = da; cmd_pict_size_in = 9'(pa); cmd_group_num_in = 8'd1;
    cmd_valid_in = 1'b1;
    tick();
    cmd_weight_base_in = wb; cmd_data_base_in = db; cmd_pict_size_in = 9'(pb);
    wait_toggle(c);
    n_checks++;
    if (c !== 2 || inst_tag_out !== 1'b1 || cmd_ready_out !== 1'b0) begin
      n_fail++; $display("FAIL held_first: lat=%0d tag=%b ready=%b want 2 1 0", c, inst_tag_out, cmd_ready_out);
    end
    n_checks++;
    if (w_obs[3] !== exp_w(wa, 0, 3) || d_obs[3] !== exp_d(da, pa, 0, 3)) begin
      n_fail++; $display("FAIL held_first_addr: w3=%h d3=%h want %h %h", w_obs[3], d_obs[3],
                         exp_w(wa, 0, 3), exp_d(da, pa, 0, 3));
    end
    pulse_done();
    wait_ldone(c, w);
    n_checks++;
    if (c !== 1 || cmd_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL held_idle: lat=%0d ready=%b busy=%b want 1 1 0", c, cmd_ready_out, busy_out);
    end
    tick();
    n_checks++;
    if (busy_out !== 1'b1 || cmd_ready_out !== 1'b0) begin
      n_fail++; $display("FAIL held_reaccept: busy=%b ready=%b want 1 0", busy_out, cmd_ready_out);
    end
    cmd_valid_in = 1'b0;
    wait_toggle(c);
    n_checks++;
    if (c !== 2 || inst_tag_out !== 1'b0) begin
      n_fail++; $display("FAIL held_second: lat=%0d tag=%b want 2 0", c, inst_tag_out);
    end
    n_checks++;
    if (w_obs[1] !== exp_w(wb, 0, 1) || d_obs[2] !== exp_d(db, pb, 0, 2)) begin
      n_fail++; $display("FAIL held_second_addr: w1=%h d2=%h want %h %h", w_obs[1], d_obs[2],
                         exp_w(wb, 0, 1), exp_d(db, pb, 0, 2));
    end
    pulse_done();
    wait_ldone(c, w);
  endtask

  task automatic test_done_ignored();
    logic [31:0] wb, db;
    int ps, c, w;
    logic t0;
    wb = $urandom; db = $urandom; ps = $urandom_range(1, 511);
    t0 = inst_tag_out;
    send_cmd(wb, db, ps, 3);
    conv_done_in = 1'b1;
    tick();
    tick();
    conv_done_in = 1'b0;
    n_checks++;
    if (inst_tag_out !== ~t0 || conv_first_out !== 1'b1) begin
      n_fail++; $display("FAIL ign_issue: tag=%b first=%b want %b 1", inst_tag_out, conv_first_out, ~t0);
    end
    repeat (4) tick();
    n_checks++;
    if (inst_tag_out !== ~t0 || conv_first_out !== 1'b1 || busy_out !== 1'b1 || w_obs[0] !== wb) begin
      n_fail++; $display("FAIL ign_hold: tag=%b first=%b busy=%b w0=%h want %b 1 1 %h",
                         inst_tag_out, conv_first_out, busy_out, w_obs[0], ~t0, wb);
    end
    for (int g = 1; g < 3; g++) begin
      pulse_done();
      wait_toggle(c);
      n_checks++;
      if (c !== 2 || conv_first_out !== 1'b0 || conv_last_out !== (g == 2)) begin
        n_fail++; $display("FAIL ign_g%0d_flags: lat=%0d first=%b last=%b", g, c, conv_first_out, conv_last_out);
      end
      n_checks++;
      if (w_obs[2] !== exp_w(wb, g, 2) || d_obs[1] !== exp_d(db, ps, g, 1)) begin
        n_fail++; $display("FAIL ign_g%0d_addr: w2=%h d1=%h want %h %h", g, w_obs[2], d_obs[1],
                           exp_w(wb, g, 2), exp_d(db, ps, g, 1));
      end
    end
    pulse_done();
    wait_ldone(c, w);
    n_checks++;
    if (c !== 1) begin n_fail++; $display("FAIL ign_ldone: lat=%0d want 1", c); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wb, db;
    int ps, c, w;
    send_cmd($urandom, $urandom, $urandom_range(1, 511), 2);
    wait_toggle(c);
    pulse_done();
    wait_toggle(c);
    Rst = 1'b1; conv_done_in = 1'b1; cmd_valid_in = 1'b1;
    tick();
    n_checks++;
    if ({w_obs[0], w_obs[1], w_obs[2], w_obs[3], d_obs[0], d_obs[1], d_obs[2], d_obs[3],
         pict_size_out, conv_first_out, conv_last_out, inst_tag_out, busy_out, layer_done_out} !== '0
        || cmd_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL midrst_clear: w0=%h d3=%h tag=%b busy=%b ready=%b want 0 0 0 0 1",
                         w_obs[0], d_obs[3], inst_tag_out, busy_out, cmd_ready_out);
    end
    Rst = 1'b0; conv_done_in = 1'b0; cmd_valid_in = 1'b0;
    tick();
    wb = $urandom; db = $urandom; ps = $urandom_range(1, 511);
    send_cmd(wb, db, ps, 2);
    wait_toggle(c);
    n_checks++;
    if (c !== 2 || inst_tag_out !== 1'b1 || conv_first_out !== 1'b1 || conv_last_out !== 1'b0
        || w_obs[3] !== exp_w(wb, 0, 3) || d_obs[3] !== exp_d(db, ps, 0, 3)) begin
      n_fail++; $display("FAIL midrst_restart: lat=%0d tag=%b first=%b last=%b w3=%h d3=%h",
                         c, inst_tag_out, conv_first_out, conv_last_out, w_obs[3], d_obs[3]);
    end
    pulse_done(); wait_toggle(c);
    pulse_done(); wait_ldone(c, w);
  endtask

  task automatic test_wrap();
    logic [31:0] ed [4] = '{32'hFFFFFFF0, 32'h00000000, 32'h00000010, 32'h00000020};
    int c, w;
    send_cmd($urandom, 32'hFFFFFFF0, 4, 1);
    wait_toggle(c);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (d_obs[n] !== ed[n]) begin n_fail++; $display("FAIL wrap_d%0d: got %h want %h", n, d_obs[n], ed[n]); end
    end
    pulse_done();
    wait_ldone(c, w);
  endtask

  task automatic test_random_layers();
    logic [31:0] wb, db;
    int ps, gn, cnt, c, w;
    for (int k = 0; k < 15; k++) begin
      wb = $urandom; db = $urandom; ps = $urandom_range(0, 511); gn = $urandom_range(0, 4);
      cnt = (gn == 0) ? 1 : gn;
      send_cmd(wb, db, ps, gn);
      for (int g = 0; g < cnt; g++) begin
        wait_toggle(c);
        n_checks++;
        if (c !== 2 || conv_first_out !== (g == 0) || conv_last_out !== (g == cnt - 1)
            || pict_size_out !== 9'(ps) || busy_out !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_g%0d_ctl: lat=%0d first=%b last=%b pict=%0d busy=%b",
                             k, g, c, conv_first_out, conv_last_out, pict_size_out, busy_out);
        end
        for (int n = 0; n < 4; n++) begin
          n_checks++;
          if (w_obs[n] !== exp_w(wb, g, n) || d_obs[n] !== exp_d(db, ps, g, n)) begin
            n_fail++; $display("FAIL rnd%0d_g%0d_ch%0d: w=%h d=%h want %h %h", k, g, n, w_obs[n], d_obs[n],
                               exp_w(wb, g, n), exp_d(db, ps, g, n));
          end
        end
        repeat ($urandom_range(0, 3)) tick();
        pulse_done();
      end
      wait_ldone(c, w);
      n_checks++;
      if (c !== 1 || w !== 1 || cmd_ready_out !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_ldone: lat=%0d width=%0d ready=%b want 1 1 1", k, c, w, cmd_ready_out);
      end
    end
  endtask

  initial begin
    Rst = 1'b1; cmd_valid_in = 1'b0; conv_done_in = 1'b0;
    cmd_weight_base_in = 32'h0; cmd_data_base_in = 32'h0;
    cmd_pict_size_in = 9'd0; cmd_group_num_in = 8'd0;
    test_reset();
    test_two_group();
    test_zero_groups();
    test_valid_held();
    test_done_ignored();
    test_reset_mid();
    test_wrap();
    test_random_layers();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
